click_mod_gate: RTL

- Upstream conditioning stage for ddr_data: takes raw 32-bit click timestamps from the TDC path and produces the tvalid200 / tdata200 / tdata200_mod detection stream that ddr_data consumes.
- Computes the click phase (timestamp modulo the gate period) with an iterative restoring divider.
- Classifies the phase against the gate_pos0..3 windows and counts clicks per PPS second for AXIL monitoring.

---
 rtl/ddr_pkg.sv | 16 +
 rtl/mod_div_iter.sv | 56 +++++
 rtl/click_mod_gate.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ddr_pkg.sv
// Shared definitions for the ddr_data path: default gate period, click FSM states
// and gate-window indices.
package ddr_pkg;
  localparam int CLICK_PERIOD = 625;
  localparam int CLICK_TW     = 32;
  localparam int CLICK_RW     = 10;

  localparam int GATE0 = 0;
  localparam int GATE1 = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    OUT  = 2'd2
  } click_state_t;
endpackage

// File: rtl/mod_div_iter.sv
// Iterative restoring divider returning dividend mod PERIOD, one quotient bit per
// cycle; done is high during the final iteration and remainder is valid after it.
module mod_div_iter
  import ddr_pkg::*;
#(
  parameter int PERIOD = CLICK_PERIOD,
  parameter int TW     = CLICK_TW,
  parameter int RW     = CLICK_RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [TW-1:0] dividend,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] remainder
);
  localparam int CW = $clog2(TW);

  logic [TW-1:0] shift_r;
  logic [RW-1:0] rem_r;
  logic [CW-1:0] cnt_r;
  logic          busy_r;
  logic [RW:0]   rem_ext;
  logic [RW:0]   rem_nxt;

  // One extra bit keeps {rem, bit} < 2*PERIOD representable, so the result fits RW bits.
  always_comb begin
    rem_ext = {rem_r, shift_r[TW-1]};
    rem_nxt = rem_ext;
    if (rem_ext >= (RW+1)'(PERIOD)) rem_nxt = rem_ext - (RW+1)'(PERIOD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= '0;
      rem_r   <= '0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else if (start && !busy_r) begin
      shift_r <= dividend;
      rem_r   <= '0;
      cnt_r   <= CW'(TW - 1);
      busy_r  <= 1'b1;
    end else if (busy_r) begin
      rem_r   <= RW'(rem_nxt);
      shift_r <= {shift_r[TW-2:0], 1'b0};
      cnt_r   <= cnt_r - 1'b1;
      if (cnt_r == '0) busy_r <= 1'b0;
    end
  end

  assign busy      = busy_r;
  assign done      = busy_r && (cnt_r == '0);
  assign remainder = rem_r;
endmodule

// File: rtl/click_mod_gate.sv
// Click conditioning for ddr_data: timestamp phase mod PERIOD, gate-window
// classification, per-PPS click counting and busy-drop counting.
module click_mod_gate
  import ddr_pkg::*;
#(
  parameter int PERIOD = CLICK_PERIOD,
  parameter int TW     = CLICK_TW,
  parameter int RW     = CLICK_RW
) (
  input  logic          clk200_i,
  input  logic          click_rstn,
  input  logic          pps_i,
  input  logic          s_click_valid,
  input  logic [TW-1:0] s_click_data,
  output logic          s_click_ready,
  input  logic [31:0]   gate_pos0,
  input  logic [31:0]   gate_pos1,
  input  logic [31:0]   gate_pos2,
  input  logic [31:0]   gate_pos3,
  output logic          tvalid200,
  output logic [TW-1:0] tdata200,
  output logic [15:0]   tdata200_mod,
  output logic [1:0]    click_gate,
  output logic [31:0]   sr_click_count_pps,
  output logic [15:0]   sr_drop_count,
  output logic [1:0]    dbg_state
);
  click_state_t  state_r, state_nx;
  logic          ready_r;
  logic          accept;
  logic [TW-1:0] ts_r;
  logic          div_busy, div_done;
  logic [RW-1:0] div_rem;
  logic [31:0]   phase;
  logic [1:0]    in_gate;
  logic          pps_s1, pps_s2, pps_s3, pps_tick;
  logic [31:0]   run_cnt;

  // Handshake: a timestamp is taken when s_click_valid is high while s_click_ready is
  // high; a valid seen with ready low is not stalled but dropped and counted. ready
  // stays low for one extra cycle after OUT, so a valid arriving then is also dropped.
  assign accept        = s_click_valid && (state_r == IDLE) && ready_r && !div_busy;
  assign s_click_ready = (state_r == IDLE) && ready_r;
  assign dbg_state     = state_r;

  mod_div_iter #(.PERIOD(PERIOD), .TW(TW), .RW(RW)) u_div (
    .clk       (clk200_i),
    .rst_n     (click_rstn),
    .start     (accept),
    .dividend  (s_click_data),
    .busy      (div_busy),
    .done      (div_done),
    .remainder (div_rem)
  );

  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE:    if (accept) state_nx = DIV;
      DIV:     if (div_done) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    phase            = 32'(div_rem);
    in_gate          = '0;
    in_gate[GATE0]   = (phase >= gate_pos0) && (phase < gate_pos1);
    in_gate[GATE1]   = (phase >= gate_pos2) && (phase < gate_pos3);
  end

  assign pps_tick = pps_s2 && !pps_s3;

  always_ff @(posedge clk200_i or negedge click_rstn) begin
    if (!click_rstn) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
      ts_r    <= '0;
    end else begin
      state_r <= state_nx;
      ready_r <= (state_r != OUT);
      if (accept) ts_r <= s_click_data;
    end
  end

  always_ff @(posedge clk200_i or negedge click_rstn) begin
    if (!click_rstn) begin
      tvalid200    <= 1'b0;
      tdata200     <= '0;
      tdata200_mod <= '0;
      click_gate   <= '0;
    end else begin
      tvalid200 <= (state_r == OUT);
      if (state_r == OUT) begin
        tdata200     <= ts_r;
        tdata200_mod <= 16'(div_rem);
        click_gate   <= in_gate;
      end
    end
  end

  always_ff @(posedge clk200_i or negedge click_rstn) begin
    if (!click_rstn) begin
      sr_drop_count <= '0;
    end else if (s_click_valid && !accept && (sr_drop_count != 16'hFFFF)) begin
      sr_drop_count <= sr_drop_count + 1'b1;
    end
  end

  // A click emitted in the same cycle as pps_tick opens the new second.
  always_ff @(posedge clk200_i or negedge click_rstn) begin
    if (!click_rstn) begin
      pps_s1             <= 1'b0;
      pps_s2             <= 1'b0;
      pps_s3             <= 1'b0;
      run_cnt            <= '0;
      sr_click_count_pps <= '0;
    end else begin
      pps_s1 <= pps_i;
      pps_s2 <= pps_s1;
      pps_s3 <= pps_s2;
      if (pps_tick) begin
        sr_click_count_pps <= run_cnt;
        run_cnt            <= tvalid200 ? 32'd1 : 32'd0;
      end else if (tvalid200 && (run_cnt != 32'hFFFF_FFFF)) begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end
endmodule
